bp_be_ptw_walker: RTL and testbench
===================================

// Module: bp_be_ptw_walker
// PURPOSE
//  Sv39 hardware page-table walker for the BE. Accepts I/D-TLB misses, walks the tables through a
//  dcache read port, then either writes a TLB fill or raises a page-fault pulse. Fault pulses feed
//  bp_be_ptw_pkt (instr/load/store_page_fault_v) consumed by the system pipe.
// PARAMETERS
//  vaddr_width_p      39  virtual address width (Sv39)
//  paddr_width_p      40  physical address width
//  ppn_width_p        28  physical page number width
//  page_idx_width_p   9   VPN slice per level
//  pte_width_p        64  PTE / dcache data width
// PORTS
//  clk_i             in   1      clock
//  reset_i           in   1      synchronous, active-high reset
//  flush_i           in   1      abort current walk (pipeline flush / satp write)
//  base_ppn_i        in   28     satp.PPN root table
//  priv_mode_i       in   2      current privilege (0=U, 1=S, 3=M)
//  miss_v_i          in   1      TLB miss request valid
//  miss_ready_o      out  1      walker can accept miss
//  miss_vaddr_i      in   39     faulting vaddr
//  miss_instr_i      in   1      1=fetch miss; else data
//  miss_store_i      in   1      1=store (ignored when miss_instr_i)
//  dcache_v_o        out  1      PTE read request valid
//  dcache_ready_i    in   1      dcache accepts request
//  dcache_paddr_o    out  40     PTE address
//  dcache_v_i        in   1      PTE read data valid
//  dcache_data_i     in   64     PTE
//  tlb_w_v_o         out  1      TLB fill pulse
//  tlb_w_itlb_o      out  1      1=fill ITLB, 0=DTLB
//  tlb_w_vtag_o      out  27     vaddr[38:12]
//  tlb_w_ppn_o       out  28     leaf PPN, superpage low bits replaced by VPN bits
//  tlb_w_lvl_o       out  2      leaf level (2=1GiB, 1=2MiB, 0=4KiB)
//  tlb_w_flags_o     out  8      PTE[7:0] (D,A,G,U,X,W,R,V)
//  instr_page_fault_v_o / load_page_fault_v_o / store_page_fault_v_o  out 1 each  fault pulse
//  fault_vaddr_o     out  39     vaddr of faulting walk (valid with a fault pulse)
//  walk_cnt_o        out  32     completed walks (perf)
//  fault_cnt_o       out  32     faulting walks (perf)
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0; all valid/pulse outputs 0; counters 0; miss_ready_o=1.
//  - States: IDLE->SEND->WAIT->CHECK->{SEND|WRITE|FAULT}->IDLE.
//  - IDLE: miss_ready_o = ~pending. On miss_v_i&miss_ready_o: latch vaddr/type, lvl=2, ppn=base_ppn_i; ->SEND.
//  - SEND: dcache_v_o=1, dcache_paddr_o={ppn_r, vpn[lvl], 3'b000}; ->WAIT when dcache_ready_i.
//  - WAIT: on dcache_v_i register PTE; ->CHECK. Requests/responses are 1:1, in order.
//  - CHECK (evaluates registered PTE):
//    V=0, or R=0&W=1 -> FAULT.
//    R=0&X=0 (pointer): lvl==0 -> FAULT; else lvl-=1, ppn_r=PTE[37:10] -> SEND.
//    Leaf faults: fetch needs X; load needs R; store needs W; A=0 -> FAULT; store&D=0 -> FAULT;
//    U-mode needs U=1; S-mode with U=1 -> FAULT; lvl>0 with nonzero PPN[lvl*9-1:0] (misaligned superpage) -> FAULT.
//    Else -> WRITE.
//  - WRITE: tlb_w_v_o=1 for exactly 1 cycle; walk_cnt++; ->IDLE.
//  - FAULT: exactly one of the three fault pulses for 1 cycle, chosen by latched type; fault_vaddr_o=latched vaddr; fault_cnt++; ->IDLE.
//  - M-mode misses never arrive (translation off); no special handling.
//  - Latency with dcache_ready_i=1 and response 1 cycle after request: 3 cycles/level; 4KiB fill pulses 10 cycles after accept.
//  - flush_i: any state -> IDLE next cycle; no fill/fault emitted that cycle or later for that walk.
//    Flush in WAIT sets pending=1; the stale response is dropped and clears pending; miss_ready_o stays 0 until then.
//    flush_i concurrent with miss_v_i in IDLE: miss not accepted.
//  - Counters wrap modulo 2^32. Reset mid-walk: immediate return to reset state, pending cleared.
// CONFIGURATION
//  BP_BE_PTW_PERF_EN defined: walk_cnt_o/fault_cnt_o live as above.
//  Not defined: counter flops not built; both outputs tied to 32'b0. All other behaviour identical.
// TESTING
//  1. 3-level 4KiB load walk, PTE V|R|W|A|D, ready=1, 1-cycle resp -> tlb_w_v_o at accept+10, lvl=0, itlb=0, exact PPN.
//  2. Level-1 leaf R|X|A, PPN low 9 bits 0, fetch vaddr 0x40_2345_6000 -> lvl=1 fill, tlb_w_ppn_o[8:0]=vaddr[20:12].
//  3. Store to leaf with D=0 -> store_page_fault_v_o 1-cycle pulse, fault_vaddr_o=miss vaddr, no tlb_w_v_o.
//  4. Level-0 PTE pointer (V=1,R=W=X=0) -> load_page_fault; level-1 leaf PPN[0]=1 -> misaligned fault.
//  5. flush_i in WAIT, response 3 cycles later -> no fill/fault, miss_ready_o=0 until response, then 1.
//  6. dcache_ready_i low 5 cycles in SEND -> dcache_paddr_o stable; U-mode leaf U=0 -> instr_page_fault_v_o.

Source files
------------

// File: rtl/bp_be_ptw_walker.sv
// bp_be_ptw_walker: Sv39 hardware page-table walker.
// Accepts I/D-TLB misses and walks the page tables through a dcache read port.
// Each walk ends with either a one-cycle TLB fill or one of the three page-fault pulses.
// Optional macro BP_BE_PTW_PERF_EN builds the walk and fault perf counters.
// When the macro is undefined, both counter outputs are tied to zero.
module bp_be_ptw_walker #(
   parameter int vaddr_width_p    = 39,
   parameter int paddr_width_p    = 40,
   parameter int ppn_width_p      = 28,
   parameter int page_idx_width_p = 9,
   parameter int pte_width_p      = 64
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        flush_i,
   input  logic [ppn_width_p-1:0]      base_ppn_i,
   input  logic [1:0]                  priv_mode_i,
   input  logic                        miss_v_i,
   output logic                        miss_ready_o,
   input  logic [vaddr_width_p-1:0]    miss_vaddr_i,
   input  logic                        miss_instr_i,
   input  logic                        miss_store_i,
   output logic                        dcache_v_o,
   input  logic                        dcache_ready_i,
   output logic [paddr_width_p-1:0]    dcache_paddr_o,
   input  logic                        dcache_v_i,
   input  logic [pte_width_p-1:0]      dcache_data_i,
   output logic                        tlb_w_v_o,
   output logic                        tlb_w_itlb_o,
   output logic [vaddr_width_p-13:0]   tlb_w_vtag_o,
   output logic [ppn_width_p-1:0]      tlb_w_ppn_o,
   output logic [1:0]                  tlb_w_lvl_o,
   output logic [7:0]                  tlb_w_flags_o,
   output logic                        instr_page_fault_v_o,
   output logic                        load_page_fault_v_o,
   output logic                        store_page_fault_v_o,
   output logic [vaddr_width_p-1:0]    fault_vaddr_o,
   output logic [31:0]                 walk_cnt_o,
   output logic [31:0]                 fault_cnt_o
);

   // state | meaning
   // IDLE  | waiting for a miss; a dropped walk's response may still be pending
   // SEND  | PTE read request on the dcache port
   // WAIT  | waiting for the PTE response
   // CHECK | decode the registered PTE: descend, fill, or fault
   // WRITE | one-cycle TLB fill pulse
   // FAULT | one-cycle page-fault pulse
   typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, WRITE, FAULT} state_e;

   state_e                           state;
   logic                             pending;
   logic [vaddr_width_p-1:0]         vaddr_r;
   logic                             instr_r;
   logic                             store_r;
   logic [1:0]                       lvl_r;
   logic [ppn_width_p-1:0]           ppn_r;
   logic [pte_width_p-1:0]           pte_r;
   logic                             tlb_v_r;
   logic                             ifault_r;
   logic                             lfault_r;
   logic                             sfault_r;
   logic                             itlb_r;
   logic [ppn_width_p-1:0]           fill_ppn_r;
   logic [1:0]                       fill_lvl_r;
   logic [7:0]                       fill_flags_r;

   logic [page_idx_width_p-1:0]      vpn_sel;
   logic [ppn_width_p-1:0]           pte_ppn;
   logic [ppn_width_p-1:0]           fill_ppn;
   logic                             pte_v, pte_r_bit, pte_w, pte_x, pte_u, pte_a, pte_d;
   logic                             invalid, pointer, misaligned, perm_fault, priv_fault, leaf_fault;
   logic                             unused_pte;

   assign unused_pte = ^{pte_r[63:38], pte_r[9:8]};

   // Decode the current VPN slice and the registered PTE
   always_comb begin
      vpn_sel   = vaddr_r[20:12];
      fill_ppn  = pte_r[37:10];
      pte_ppn   = pte_r[37:10];
      pte_v     = pte_r[0];
      pte_r_bit = pte_r[1];
      pte_w     = pte_r[2];
      pte_x     = pte_r[3];
      pte_u     = pte_r[4];
      pte_a     = pte_r[6];
      pte_d     = pte_r[7];
      case (lvl_r)
         2'd2: begin
            vpn_sel  = vaddr_r[38:30];
            fill_ppn = {pte_ppn[27:18], vaddr_r[29:12]};
         end
         2'd1: begin
            vpn_sel  = vaddr_r[29:21];
            fill_ppn = {pte_ppn[27:9], vaddr_r[20:12]};
         end
         default: begin
            vpn_sel  = vaddr_r[20:12];
            fill_ppn = pte_ppn;
         end
      endcase
      invalid    = ~pte_v | (~pte_r_bit & pte_w);
      pointer    = ~pte_r_bit & ~pte_x;
      misaligned = ((lvl_r == 2'd2) && (pte_ppn[17:0] != 18'd0))
                 | ((lvl_r == 2'd1) && (pte_ppn[8:0] != 9'd0));
      perm_fault = instr_r ? ~pte_x : (store_r ? (~pte_w | ~pte_d) : ~pte_r_bit);
      priv_fault = ((priv_mode_i == 2'd0) & ~pte_u) | ((priv_mode_i == 2'd1) & pte_u);
      leaf_fault = perm_fault | ~pte_a | priv_fault | misaligned;
   end

   // Walk sequencer with registered fill/fault pulses and stale-response tracking
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state        <= IDLE;
         pending      <= 1'b0;
         vaddr_r      <= '0;
         instr_r      <= 1'b0;
         store_r      <= 1'b0;
         lvl_r        <= 2'd0;
         ppn_r        <= '0;
         pte_r        <= '0;
         tlb_v_r      <= 1'b0;
         ifault_r     <= 1'b0;
         lfault_r     <= 1'b0;
         sfault_r     <= 1'b0;
         itlb_r       <= 1'b0;
         fill_ppn_r   <= '0;
         fill_lvl_r   <= 2'd0;
         fill_flags_r <= 8'd0;
      end else begin
         tlb_v_r  <= 1'b0;
         ifault_r <= 1'b0;
         lfault_r <= 1'b0;
         sfault_r <= 1'b0;
         if (flush_i) begin
            state <= IDLE;
            // A request already handed to the dcache still owes a response
            if (((state == SEND) && dcache_ready_i) || ((state == WAIT) && !dcache_v_i))
               pending <= 1'b1;
            else if (dcache_v_i)
               pending <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (pending) begin
                     if (dcache_v_i)
                        pending <= 1'b0;
                  end else if (miss_v_i) begin
                     vaddr_r <= miss_vaddr_i;
                     instr_r <= miss_instr_i;
                     store_r <= miss_store_i & ~miss_instr_i;
                     lvl_r   <= 2'd2;
                     ppn_r   <= base_ppn_i;
                     state   <= SEND;
                  end
               end
               SEND: begin
                  if (dcache_ready_i)
                     state <= WAIT;
               end
               WAIT: begin
                  if (dcache_v_i) begin
                     pte_r <= dcache_data_i;
                     state <= CHECK;
                  end
               end
               CHECK: begin
                  if (invalid || (pointer && (lvl_r == 2'd0)) || (!pointer && leaf_fault)) begin
                     ifault_r <= instr_r;
                     lfault_r <= ~instr_r & ~store_r;
                     sfault_r <= ~instr_r & store_r;
                     state    <= FAULT;
                  end else if (pointer) begin
                     lvl_r <= lvl_r - 2'd1;
                     ppn_r <= pte_ppn;
                     state <= SEND;
                  end else begin
                     tlb_v_r      <= 1'b1;
                     itlb_r       <= instr_r;
                     fill_ppn_r   <= fill_ppn;
                     fill_lvl_r   <= lvl_r;
                     fill_flags_r <= pte_r[7:0];
                     state        <= WRITE;
                  end
               end
               WRITE:   state <= IDLE;
               FAULT:   state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign miss_ready_o         = (state == IDLE) & ~pending;
   assign dcache_v_o           = (state == SEND);
   assign dcache_paddr_o       = {ppn_r, vpn_sel, 3'b000};
   assign tlb_w_v_o            = tlb_v_r & ~flush_i;
   assign tlb_w_itlb_o         = itlb_r;
   assign tlb_w_vtag_o         = vaddr_r[38:12];
   assign tlb_w_ppn_o          = fill_ppn_r;
   assign tlb_w_lvl_o          = fill_lvl_r;
   assign tlb_w_flags_o        = fill_flags_r;
   assign instr_page_fault_v_o = ifault_r & ~flush_i;
   assign load_page_fault_v_o  = lfault_r & ~flush_i;
   assign store_page_fault_v_o = sfault_r & ~flush_i;
   assign fault_vaddr_o        = vaddr_r;

`ifdef BP_BE_PTW_PERF_EN
   logic [31:0] walk_cnt;
   logic [31:0] fault_cnt;

   // Count walks that actually emitted a fill or a fault
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         walk_cnt  <= 32'd0;
         fault_cnt <= 32'd0;
      end else if (!flush_i) begin
         if (state == WRITE)
            walk_cnt <= walk_cnt + 32'd1;
         if (state == FAULT)
            fault_cnt <= fault_cnt + 32'd1;
      end
   end

   assign walk_cnt_o  = walk_cnt;
   assign fault_cnt_o = fault_cnt;
`else
   assign walk_cnt_o  = 32'd0;
   assign fault_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_be_ptw_walker.sv
// Directed testbench for bp_be_ptw_walker.
// The page tables live in an associative-array memory.
// A simple responder answers each accepted PTE read after resp_delay cycles.
module tb_bp_be_ptw_walker;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        flush_i;
   logic [27:0] base_ppn_i;
   logic [1:0]  priv_mode_i;
   logic        miss_v_i;
   logic        miss_ready_o;
   logic [38:0] miss_vaddr_i;
   logic        miss_instr_i;
   logic        miss_store_i;
   logic        dcache_v_o;
   logic        dcache_ready_i;
   logic [39:0] dcache_paddr_o;
   logic        dcache_v_i;
   logic [63:0] dcache_data_i;
   logic        tlb_w_v_o;
   logic        tlb_w_itlb_o;
   logic [26:0] tlb_w_vtag_o;
   logic [27:0] tlb_w_ppn_o;
   logic [1:0]  tlb_w_lvl_o;
   logic [7:0]  tlb_w_flags_o;
   logic        instr_page_fault_v_o;
   logic        load_page_fault_v_o;
   logic        store_page_fault_v_o;
   logic [38:0] fault_vaddr_o;
   logic [31:0] walk_cnt_o;
   logic [31:0] fault_cnt_o;

   int errors = 0;
   int checks = 0;
   int resp_delay = 1;

   logic [63:0] mem [logic [39:0]];
   logic [39:0] req_addr;

   int          obs_fill_cyc, obs_fill_n, obs_if_n, obs_lf_n, obs_sf_n;
   logic [27:0] cap_ppn;
   logic [1:0]  cap_lvl;
   logic [7:0]  cap_flags;
   logic [26:0] cap_vtag;
   logic        cap_itlb;
   logic [38:0] cap_fva;

   always #5 clk_i = ~clk_i;

   bp_be_ptw_walker dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .base_ppn_i(base_ppn_i),
      .priv_mode_i(priv_mode_i), .miss_v_i(miss_v_i), .miss_ready_o(miss_ready_o),
      .miss_vaddr_i(miss_vaddr_i), .miss_instr_i(miss_instr_i), .miss_store_i(miss_store_i),
      .dcache_v_o(dcache_v_o), .dcache_ready_i(dcache_ready_i), .dcache_paddr_o(dcache_paddr_o),
      .dcache_v_i(dcache_v_i), .dcache_data_i(dcache_data_i), .tlb_w_v_o(tlb_w_v_o),
      .tlb_w_itlb_o(tlb_w_itlb_o), .tlb_w_vtag_o(tlb_w_vtag_o), .tlb_w_ppn_o(tlb_w_ppn_o),
      .tlb_w_lvl_o(tlb_w_lvl_o), .tlb_w_flags_o(tlb_w_flags_o),
      .instr_page_fault_v_o(instr_page_fault_v_o), .load_page_fault_v_o(load_page_fault_v_o),
      .store_page_fault_v_o(store_page_fault_v_o), .fault_vaddr_o(fault_vaddr_o),
      .walk_cnt_o(walk_cnt_o), .fault_cnt_o(fault_cnt_o)
   );

   function automatic logic [63:0] mk_pte(input logic [27:0] ppn, input logic [7:0] flags);
      return {26'd0, ppn, 2'b00, flags};
   endfunction

   function automatic logic [63:0] lookup(input logic [39:0] addr);
      if (mem.exists(addr)) return mem[addr];
      return 64'd0;
   endfunction

   // Dcache responder: one response per accepted request, in order
   initial begin
      dcache_v_i    = 1'b0;
      dcache_data_i = 64'd0;
      forever begin
         @(negedge clk_i);
         if (dcache_v_o && dcache_ready_i) begin
            req_addr = dcache_paddr_o;
            @(posedge clk_i);
            repeat (resp_delay - 1) @(posedge clk_i);
            #1;
            dcache_v_i    = 1'b1;
            dcache_data_i = lookup(req_addr);
            @(posedge clk_i);
            #1;
            dcache_v_i = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_miss(input logic [38:0] va, input logic instr, input logic store,
                             input logic [1:0] priv);
      priv_mode_i  = priv;
      miss_vaddr_i = va;
      miss_instr_i = instr;
      miss_store_i = store;
      miss_v_i     = 1'b1;
      @(posedge clk_i);
      #1;
      miss_v_i = 1'b0;
   endtask

   // Watch a bounded window; cycle c is the cycle ending at the c-th edge after accept
   task automatic observe(input int ncyc);
      obs_fill_cyc = 0; obs_fill_n = 0; obs_if_n = 0; obs_lf_n = 0; obs_sf_n = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk_i);
         if (tlb_w_v_o) begin
            if (obs_fill_n == 0) begin
               obs_fill_cyc = c;
               cap_ppn = tlb_w_ppn_o; cap_lvl = tlb_w_lvl_o; cap_flags = tlb_w_flags_o;
               cap_vtag = tlb_w_vtag_o; cap_itlb = tlb_w_itlb_o;
            end
            obs_fill_n++;
         end
         if (instr_page_fault_v_o || load_page_fault_v_o || store_page_fault_v_o)
            cap_fva = fault_vaddr_o;
         if (instr_page_fault_v_o) obs_if_n++;
         if (load_page_fault_v_o)  obs_lf_n++;
         if (store_page_fault_v_o) obs_sf_n++;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", miss_ready_o); end
      checks++; if (dcache_v_o !== 1'b0) begin errors++; $display("FAIL reset_dcache_v: got %b want 0", dcache_v_o); end
      checks++; if ({tlb_w_v_o, instr_page_fault_v_o, load_page_fault_v_o, store_page_fault_v_o} !== 4'b0)
         begin errors++; $display("FAIL reset_pulses: got %b want 0000",
            {tlb_w_v_o, instr_page_fault_v_o, load_page_fault_v_o, store_page_fault_v_o}); end
      checks++; if ({walk_cnt_o, fault_cnt_o} !== 64'd0) begin errors++; $display("FAIL reset_counters: got %h/%h want 0/0", walk_cnt_o, fault_cnt_o); end
      reset_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_load_4k();
      mem[40'h100008] = mk_pte(28'h200, 8'h01);
      mem[40'h200010] = mk_pte(28'h300, 8'h01);
      mem[40'h300018] = mk_pte(28'h12345, 8'hC7);
      start_miss(39'h00_4040_3000, 1'b0, 1'b0, 2'd1);
      observe(16);
      checks++; if (obs_fill_n !== 1) begin errors++; $display("FAIL load4k_fill_count: got %0d want 1", obs_fill_n); end
      checks++; if (obs_fill_cyc !== 10) begin errors++; $display("FAIL load4k_latency: got %0d want 10", obs_fill_cyc); end
      checks++; if (cap_lvl !== 2'd0) begin errors++; $display("FAIL load4k_lvl: got %0d want 0", cap_lvl); end
      checks++; if (cap_itlb !== 1'b0) begin errors++; $display("FAIL load4k_itlb: got %b want 0", cap_itlb); end
      checks++; if (cap_ppn !== 28'h12345) begin errors++; $display("FAIL load4k_ppn: got %h want 12345", cap_ppn); end
      checks++; if (cap_flags !== 8'hC7) begin errors++; $display("FAIL load4k_flags: got %h want c7", cap_flags); end
      checks++; if (cap_vtag !== 27'h40403) begin errors++; $display("FAIL load4k_vtag: got %h want 40403", cap_vtag); end
      checks++; if (obs_if_n + obs_lf_n + obs_sf_n !== 0) begin errors++; $display("FAIL load4k_no_fault: got %0d want 0", obs_if_n + obs_lf_n + obs_sf_n); end
   endtask

   task automatic test_superpage_fetch();
      mem[40'h100800] = mk_pte(28'h400, 8'h01);
      mem[40'h4008D0] = mk_pte(28'h2AA00, 8'h4B);
      start_miss(39'h40_2345_6000, 1'b1, 1'b0, 2'd1);
      observe(16);
      checks++; if (obs_fill_n !== 1) begin errors++; $display("FAIL super_fill_count: got %0d want 1", obs_fill_n); end
      checks++; if (obs_fill_cyc !== 7) begin errors++; $display("FAIL super_latency: got %0d want 7", obs_fill_cyc); end
      checks++; if (cap_lvl !== 2'd1) begin errors++; $display("FAIL super_lvl: got %0d want 1", cap_lvl); end
      checks++; if (cap_itlb !== 1'b1) begin errors++; $display("FAIL super_itlb: got %b want 1", cap_itlb); end
      checks++; if (cap_ppn !== 28'h2AA56) begin errors++; $display("FAIL super_ppn: got %h want 2aa56", cap_ppn); end
      checks++; if (cap_flags !== 8'h4B) begin errors++; $display("FAIL super_flags: got %h want 4b", cap_flags); end
   endtask

   task automatic test_store_dirty();
      mem[40'h300020] = mk_pte(28'h55, 8'h47);
      start_miss(39'h00_4040_4000, 1'b0, 1'b1, 2'd1);
      observe(16);
      checks++; if (obs_sf_n !== 1) begin errors++; $display("FAIL store_fault_pulse: got %0d cycles want 1", obs_sf_n); end
      checks++; if (obs_if_n + obs_lf_n !== 0) begin errors++; $display("FAIL store_other_faults: got %0d want 0", obs_if_n + obs_lf_n); end
      checks++; if (obs_fill_n !== 0) begin errors++; $display("FAIL store_no_fill: got %0d want 0", obs_fill_n); end
      checks++; if (cap_fva !== 39'h00_4040_4000) begin errors++; $display("FAIL store_fault_vaddr: got %h want 0040404000", cap_fva); end
   endtask

   task automatic test_pointer_misaligned();
      mem[40'h300028] = mk_pte(28'h77, 8'h01);
      start_miss(39'h00_4040_5000, 1'b0, 1'b0, 2'd1);
      observe(16);
      checks++; if (obs_lf_n !== 1) begin errors++; $display("FAIL lvl0_pointer_fault: got %0d want 1", obs_lf_n); end
      checks++; if (obs_fill_n + obs_if_n + obs_sf_n !== 0) begin errors++; $display("FAIL lvl0_pointer_other: got %0d want 0", obs_fill_n + obs_if_n + obs_sf_n); end
      mem[40'h200018] = mk_pte(28'h401, 8'h43);
      start_miss(39'h00_4060_0000, 1'b0, 1'b0, 2'd1);
      observe(16);
      checks++; if (obs_lf_n !== 1) begin errors++; $display("FAIL misaligned_fault: got %0d want 1", obs_lf_n); end
      checks++; if (obs_fill_n !== 0) begin errors++; $display("FAIL misaligned_no_fill: got %0d want 0", obs_fill_n); end
      checks++; if (cap_fva !== 39'h00_4060_0000) begin errors++; $display("FAIL misaligned_vaddr: got %h want 0040600000", cap_fva); end
   endtask

   task automatic test_flush_wait();
      resp_delay = 3;
      start_miss(39'h00_4040_3000, 1'b0, 1'b0, 2'd1);
      @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      checks++; if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_e2: got %b want 0", miss_ready_o); end
      @(posedge clk_i);
      #1;
      checks++; if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_e3: got %b want 0", miss_ready_o); end
      @(posedge clk_i);
      #1;
      checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready_after_resp: got %b want 1", miss_ready_o); end
      resp_delay = 1;
      observe(12);
      checks++; if (obs_fill_n + obs_if_n + obs_lf_n + obs_sf_n !== 0) begin errors++; $display("FAIL flush_no_output: got %0d pulses want 0", obs_fill_n + obs_if_n + obs_lf_n + obs_sf_n); end
      checks++; if (dcache_v_o !== 1'b0) begin errors++; $display("FAIL flush_no_request: got %b want 0", dcache_v_o); end
   endtask

   task automatic test_flush_idle();
      miss_vaddr_i = 39'h00_4040_3000;
      miss_instr_i = 1'b0;
      miss_store_i = 1'b0;
      miss_v_i     = 1'b1;
      flush_i      = 1'b1;
      @(posedge clk_i);
      #1;
      miss_v_i = 1'b0;
      flush_i  = 1'b0;
      checks++; if (dcache_v_o !== 1'b0) begin errors++; $display("FAIL flush_idle_not_accepted: got %b want 0", dcache_v_o); end
      checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got %b want 1", miss_ready_o); end
   endtask

   task automatic test_stall_umode();
      mem[40'h300030] = mk_pte(28'h66, 8'h4B);
      dcache_ready_i = 1'b0;
      start_miss(39'h00_4040_6000, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         checks++; if (dcache_v_o !== 1'b1 || dcache_paddr_o !== 40'h100008)
            begin errors++; $display("FAIL stall_paddr[%0d]: got v=%b %h want v=1 0000100008", i, dcache_v_o, dcache_paddr_o); end
      end
      dcache_ready_i = 1'b1;
      observe(16);
      checks++; if (obs_if_n !== 1) begin errors++; $display("FAIL umode_instr_fault: got %0d want 1", obs_if_n); end
      checks++; if (obs_fill_n + obs_lf_n + obs_sf_n !== 0) begin errors++; $display("FAIL umode_other: got %0d want 0", obs_fill_n + obs_lf_n + obs_sf_n); end
      checks++; if (cap_fva !== 39'h00_4040_6000) begin errors++; $display("FAIL umode_vaddr: got %h want 0040406000", cap_fva); end
      priv_mode_i = 2'd1;
   endtask

   task automatic test_counters();
      logic [31:0] exp_walk, exp_fault;
`ifdef BP_BE_PTW_PERF_EN
      exp_walk  = 32'd2;
      exp_fault = 32'd4;
`else
      exp_walk  = 32'd0;
      exp_fault = 32'd0;
`endif
      checks++; if (walk_cnt_o !== exp_walk) begin errors++; $display("FAIL walk_cnt: got %0d want %0d", walk_cnt_o, exp_walk); end
      checks++; if (fault_cnt_o !== exp_fault) begin errors++; $display("FAIL fault_cnt: got %0d want %0d", fault_cnt_o, exp_fault); end
   endtask

   task automatic test_reset_midwalk();
      dcache_ready_i = 1'b0;
      start_miss(39'h00_4040_3000, 1'b0, 1'b0, 2'd1);
      checks++; if (dcache_v_o !== 1'b1) begin errors++; $display("FAIL midwalk_send: got %b want 1", dcache_v_o); end
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      reset_i        = 1'b0;
      dcache_ready_i = 1'b1;
      checks++; if (dcache_v_o !== 1'b0) begin errors++; $display("FAIL midwalk_reset_v: got %b want 0", dcache_v_o); end
      checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL midwalk_reset_ready: got %b want 1", miss_ready_o); end
      checks++; if ({walk_cnt_o, fault_cnt_o} !== 64'd0) begin errors++; $display("FAIL midwalk_reset_cnt: got %h/%h want 0/0", walk_cnt_o, fault_cnt_o); end
      observe(8);
      checks++; if (obs_fill_n + obs_if_n + obs_lf_n + obs_sf_n !== 0) begin errors++; $display("FAIL midwalk_no_output: got %0d want 0", obs_fill_n + obs_if_n + obs_lf_n + obs_sf_n); end
   endtask

   initial begin
      reset_i        = 1'b1;
      flush_i        = 1'b0;
      base_ppn_i     = 28'h100;
      priv_mode_i    = 2'd1;
      miss_v_i       = 1'b0;
      miss_vaddr_i   = 39'd0;
      miss_instr_i   = 1'b0;
      miss_store_i   = 1'b0;
      dcache_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      test_reset();
      test_load_4k();
      test_superpage_fetch();
      test_store_dirty();
      test_pointer_misaligned();
      test_flush_wait();
      test_flush_idle();
      test_stall_umode();
      test_counters();
      test_reset_midwalk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
